// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM Wishbone arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, GNT0, GNT1)
//   M0 / M1     : master index constants used by the round-robin `last` register
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/sram_arb_watchdog.sv
// Per-transfer watchdog for the SRAM arbiter.
//   clk    : clock, counter updates on posedge
//   rst    : asynchronous active-high reset
//   active : a granted master has cyc & stb asserted
//   done   : slave terminated the beat (ack or err)
//   expire : counter reached TIMEOUT while active; arbiter errors the beat
// The counter clears on reaching TIMEOUT, so it never wraps (TIMEOUT < 2**TW).
module sram_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire
);

    logic [TW-1:0] wdog_r;
    logic [TW-1:0] wdog_nxt_s;
    logic          at_limit_s;

    assign at_limit_s = (wdog_r == TW'(TIMEOUT));
    assign expire     = active & at_limit_s;

    // Next count: clear when idle, terminated or expired, otherwise count up.
    always_comb begin
        wdog_nxt_s = {TW{1'b0}};
        if (!active || done || at_limit_s) begin
            wdog_nxt_s = {TW{1'b0}};
        end else begin
            wdog_nxt_s = wdog_r + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_r <= {TW{1'b0}};
        end else begin
            wdog_r <= wdog_nxt_s;
        end
    end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single-ported SRAM slave.
//   wb_clk_i / wb_rst_i       : clock / asynchronous active-high reset
//   m0_* (instruction bus)    : adr/dat/sel/we/cyc/stb in, dat/ack/err out
//   m1_* (data bus)           : same as m0_*
//   s_*                       : master-side Wishbone port towards the SRAM
// The grant is held for the whole cyc so bursts are locked; routing is purely
// combinational so same-cycle slave acks are supported.
module sram_wb_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic       wd_active_s;
    logic       wd_done_s;
    logic       wd_expire_s;

    // Watchdog runs only while the granted master strobes.
    always_comb begin
        wd_active_s = 1'b0;
        case (state_r)
            GNT0:    wd_active_s = m0_cyc_i & m0_stb_i;
            GNT1:    wd_active_s = m1_cyc_i & m1_stb_i;
            default: wd_active_s = 1'b0;
        endcase
    end

    assign wd_done_s = s_ack_i | s_err_i;

    sram_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .active (wd_active_s),
        .done   (wd_done_s),
        .expire (wd_expire_s)
    );

    // Next-state / round-robin: a tie goes to the master that was not served last;
    // a release hands straight over to a waiting master without an idle cycle.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt_s = (last_r == M1) ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt_s = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_nxt_s  = M0;
                    state_nxt_s = m1_cyc_i ? GNT1 : IDLE;
                end else begin
                    state_nxt_s = GNT0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_nxt_s  = M1;
                    state_nxt_s = m0_cyc_i ? GNT0 : IDLE;
                end else begin
                    state_nxt_s = GNT1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                last_nxt_s  = M1;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            last_r  <= M1;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Request path to the slave; stb is withheld on the cycle the watchdog fires.
    always_comb begin
        s_adr_o = 32'h0000_0000;
        s_dat_o = 32'h0000_0000;
        s_sel_o = 4'h0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_r)
            GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & ~wd_expire_s;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & ~wd_expire_s;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    // Response path; kept apart from the request path because a combinational
    // slave closes the loop stb -> ack.
    always_comb begin
        m0_dat_o = 32'h0000_0000;
        m1_dat_o = 32'h0000_0000;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_r)
            GNT0: begin
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & ~wd_expire_s;
                m0_err_o = s_err_i | wd_expire_s;
            end
            GNT1: begin
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & ~wd_expire_s;
                m1_err_o = s_err_i | wd_expire_s;
            end
            default: begin
                m0_ack_o = 1'b0;
            end
        endcase
    end

endmodule
